// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, parallel load, multi-step shift L/R.
// Define UNIV_SHIFT_REG_ROTATE_EN to make the shift modes rotate instead of filling from sin.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             r,
    input  logic [1:0]       pe,
    input  logic             start,
    input  logic [SHW-1:0]   amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] PE_HOLD  = 2'b00;
    localparam logic [1:0] PE_RIGHT = 2'b01;
    localparam logic [1:0] PE_LEFT  = 2'b10;
    localparam logic [1:0] PE_LOAD  = 2'b11;

    state_t           state_q, state_d;
    logic             left_q, left_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             left;
    logic             out_bit;
    logic             fill;
    logic [WIDTH-1:0] shifted;

    // Direction comes from pe on the start edge, from the latched mode afterwards.
    always_comb begin
        left    = (state_q == SHIFT) ? left_q : pe[1];
        out_bit = left ? data_q[WIDTH-1] : data_q[0];
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        fill    = out_bit;
`else
        fill    = sin;
`endif
        shifted = left ? {data_q[WIDTH-2:0], fill}
                       : {fill, data_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        count_d = count_q;
        data_d  = data_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (pe)
                        PE_HOLD: begin
                            done_d = 1'b1;
                        end
                        PE_LOAD: begin
                            data_d = d;
                            done_d = 1'b1;
                        end
                        PE_RIGHT, PE_LEFT: begin
                            if (amt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                data_d  = shifted;
                                sout_d  = out_bit;
                                left_d  = pe[1];
                                count_d = amt - SHW'(1);
                                if (amt == SHW'(1)) begin
                                    done_d = 1'b1;
                                end else begin
                                    state_d = SHIFT;
                                    busy_d  = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                data_d  = shifted;
                sout_d  = out_bit;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(negedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            left_q  <= 1'b0;
            count_q <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            count_q <= count_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = data_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the 4-bit parallel-load register: a WIDTH-bit universal register with hold, parallel load, and multi-step shift-left/right.
- Multi-step shifts are sequenced by a small FSM with start/busy/done handshake and a serial in/out.
- Used as the general storage/shift element in the datapath; state updates on the falling edge of clk, as in the existing register family.

Parameters:
- WIDTH, 8, data width in bits (>=2).
- SHW, 3, width of shift-amount input amt.

Ports:
- clk  in  1  clock; all state updates on falling edge.
- r  in  1  reset, asynchronous, active-low.
- pe  in  2  mode, sampled at start: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- start  in  1  command strobe, sampled on falling edge while idle.
- amt  in  SHW  number of single-bit shifts for modes 01/10.
- d  in  WIDTH  parallel load data.
- sin  in  1  serial fill bit, sampled on every shift edge.
- q  out  WIDTH  register contents.
- sout  out  1  registered copy of the last bit shifted out.
- busy  out  1  multi-step shift in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: r low forces q=0, sout=0, busy=0, done=0, FSM=IDLE, count=0 immediately, independent of clk. Reset mid-operation aborts the shift; no partial completion is reported.
- done defaults low each edge; it is high only for the one cycle following a completing edge.
- FSM states are IDLE and SHIFT.
- IDLE, start=0: q holds.
- IDLE, start=1, pe=00: q holds; done=1.
- IDLE, start=1, pe=11: q<=d on that edge; done=1; busy stays 0.
- IDLE, start=1, pe=01/10, amt=0: q unchanged; done=1.
- IDLE, start=1, pe=01/10, amt>=1:
  - The first shift happens on the start edge.
  - Mode is latched and count<=amt-1.
  - If amt=1: done=1 and the FSM stays IDLE. Otherwise go to SHIFT with busy=1.
- SHIFT: one shift per falling edge, count decrements.
  - On the edge where count reaches 0: busy<=0, done<=1, return to IDLE.
  - Total shifts = amt, performed on edges k..k+amt-1 (k = start edge).
- Shift right: q<={fill, q[WIDTH-1:1]}; sout<=q[0].
- Shift left: q<={q[WIDTH-2:0], fill}; sout<=q[WIDTH-1].
- fill=sin, sampled on each shift edge. amt>WIDTH is legal; the register simply fills completely.
- While busy: start, pe, amt and d are ignored. A start on the completing edge is also ignored; a new command is accepted from the next edge.
- sout changes only on shift edges; it holds through load and hold.

Optional Feature:
- UNIV_SHIFT_REG_ROTATE_EN defined: shift modes rotate. fill = the bit shifted out on the same edge; sin is ignored.
- Not defined: fill comes from sin; no rotate logic is synthesised.
- The handshake and timing are identical in both builds.

Test Plan:
- Reset: q=FF via load, then r=0 asynchronously between edges -> q=00, sout=0, busy=0, done=0 immediately.
- Load: pe=11, d=A5, start for one edge -> q=A5 after that edge; done high for one cycle; busy never high.
- Shift right, no rotate: q=A5, pe=01, amt=3, sin=1, start ->
  - busy high after edges 1-2; after edge 3 q=F4, sout=1, busy=0, done=1 for one cycle.
  - Repeat with ROTATE_EN -> q=B4.
- Shift left, no rotate: q=A5, pe=10, amt=2, sin=0 -> q=94, sout=0 after edge 2.
  - With ROTATE_EN -> q=96.
- Ignored/empty commands:
  - start with pe=01, amt=0 -> q unchanged, done pulse next cycle.
  - start pulses (pe=11, d=00) during a busy amt=5 shift -> ignored; the final q equals the 5-shift result.
- Reset mid-shift: amt=6 started, r low after edge 2 -> all outputs 0, no done. After release, a load of 3C completes normally with q=3C.
